// File: rtl/operand_stage_pkg.sv
// Shared types and width helpers for the operand stage.
package operand_stage_pkg;

   localparam int unsigned DEF_DATA_WIDTH_POW = 6;
   localparam int unsigned REG_ADDR_W         = 5;

   function automatic int unsigned data_width(input int unsigned pow);
      return 32'd1 << pow;
   endfunction

   localparam int unsigned DATA_WIDTH = data_width(DEF_DATA_WIDTH_POW);

   // Control half of the registered bundle; operands sit beside it because
   // their width follows the module parameter.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  mem_read;
   } operand_bundle_t;

   typedef enum logic {StEmpty, StFull} stage_state_e;

endpackage

// File: rtl/operand_stage_if.sv
// Upstream/downstream/bypass signal bundle of the operand stage.
interface operand_stage_if import operand_stage_pkg::*; #(
   parameter int unsigned DATA_WIDTH_POW = DEF_DATA_WIDTH_POW
) ();
   localparam int unsigned Dw = data_width(DATA_WIDTH_POW);

   logic                  inst_valid_in;
   logic                  inst_ready_out;
   logic [REG_ADDR_W-1:0] rs1_in;
   logic [REG_ADDR_W-1:0] rs2_in;
   logic [REG_ADDR_W-1:0] rd_in;
   logic                  regWrite_in;
   logic                  memRead_in;
   logic [Dw-1:0]         rs1Data_in;
   logic [Dw-1:0]         rs2Data_in;
   logic [REG_ADDR_W-1:0] exRd_in;
   logic                  exRegWrite_in;
   logic                  exMemRead_in;
   logic [Dw-1:0]         exResult_in;
   logic [REG_ADDR_W-1:0] wbRd_in;
   logic                  wbRegWrite_in;
   logic [Dw-1:0]         wbData_in;
   logic                  flush_in;
   logic                  ready_in;
   logic                  valid_out;
   logic [Dw-1:0]         op1_out;
   logic [Dw-1:0]         op2_out;
   logic [REG_ADDR_W-1:0] rd_out;
   logic                  regWrite_out;
   logic                  memRead_out;

   modport master (
      output inst_valid_in, rs1_in, rs2_in, rd_in, regWrite_in, memRead_in,
             rs1Data_in, rs2Data_in, exRd_in, exRegWrite_in, exMemRead_in, exResult_in,
             wbRd_in, wbRegWrite_in, wbData_in, flush_in, ready_in,
      input  inst_ready_out, valid_out, op1_out, op2_out, rd_out, regWrite_out, memRead_out
   );

   modport slave (
      input  inst_valid_in, rs1_in, rs2_in, rd_in, regWrite_in, memRead_in,
             rs1Data_in, rs2Data_in, exRd_in, exRegWrite_in, exMemRead_in, exResult_in,
             wbRd_in, wbRegWrite_in, wbData_in, flush_in, ready_in,
      output inst_ready_out, valid_out, op1_out, op2_out, rd_out, regWrite_out, memRead_out
   );
endinterface

// File: rtl/operand_fwd_mux.sv
// Per-source operand select and RAW stall detection.
// OPERAND_FORWARD_EN enables EX/WB bypass; otherwise any RAW match stalls.
module operand_fwd_mux import operand_stage_pkg::*; #(
   parameter int unsigned Dw = DATA_WIDTH
) (
   input  logic [REG_ADDR_W-1:0] rs_i,
   input  logic [Dw-1:0]         rf_data_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_i,
   input  logic                  ex_reg_write_i,
   input  logic                  ex_mem_read_i,
   input  logic [Dw-1:0]         ex_result_i,
   input  logic [REG_ADDR_W-1:0] wb_rd_i,
   input  logic                  wb_reg_write_i,
   input  logic [Dw-1:0]         wb_data_i,
   output logic [Dw-1:0]         data_o,
   output logic                  stall_o
);
   logic rs_zero, ex_hit, wb_hit;

   assign rs_zero = (rs_i == '0);
   assign ex_hit  = !rs_zero && ex_reg_write_i && (ex_rd_i == rs_i);
   assign wb_hit  = !rs_zero && wb_reg_write_i && (wb_rd_i == rs_i);

`ifdef OPERAND_FORWARD_EN
   always_comb begin
      data_o  = rf_data_i;
      stall_o = ex_hit && ex_mem_read_i;
      if (rs_zero) begin
         data_o = '0;
      end else if (ex_hit && !ex_mem_read_i) begin
         data_o = ex_result_i;
      end else if (wb_hit) begin
         // Register file returns the old value during its write cycle.
         data_o = wb_data_i;
      end
   end
`else
   logic unused_bypass;
   assign unused_bypass = ^{ex_mem_read_i, ex_result_i, wb_data_i};

   always_comb begin
      data_o  = rs_zero ? '0 : rf_data_i;
      stall_o = ex_hit || wb_hit;
   end
`endif

endmodule

// File: rtl/operand_stage.sv
// Operand-fetch pipeline stage: bypass selection, hazard stall, one-entry output register.
// Build option OPERAND_FORWARD_EN enables EX/WB forwarding (see operand_fwd_mux).
module operand_stage import operand_stage_pkg::*; #(
   parameter int unsigned DATA_WIDTH_POW = DEF_DATA_WIDTH_POW
) (
   input  logic            clk_in,
   input  logic            reset,
   operand_stage_if.slave  bus
);
   localparam int unsigned Dw = data_width(DATA_WIDTH_POW);

   logic [Dw-1:0]   fwd1, fwd2;
   logic            haz1, haz2;
   logic            hazard, valid, ready, accept;
   stage_state_e    state_q, state_d;
   logic [Dw-1:0]   op1_q, op1_d, op2_q, op2_d;
   operand_bundle_t ctrl_q, ctrl_d;

   operand_fwd_mux #(.Dw(Dw)) u_fwd_rs1 (
      .rs_i           (bus.rs1_in),
      .rf_data_i      (bus.rs1Data_in),
      .ex_rd_i        (bus.exRd_in),
      .ex_reg_write_i (bus.exRegWrite_in),
      .ex_mem_read_i  (bus.exMemRead_in),
      .ex_result_i    (bus.exResult_in),
      .wb_rd_i        (bus.wbRd_in),
      .wb_reg_write_i (bus.wbRegWrite_in),
      .wb_data_i      (bus.wbData_in),
      .data_o         (fwd1),
      .stall_o        (haz1)
   );

   operand_fwd_mux #(.Dw(Dw)) u_fwd_rs2 (
      .rs_i           (bus.rs2_in),
      .rf_data_i      (bus.rs2Data_in),
      .ex_rd_i        (bus.exRd_in),
      .ex_reg_write_i (bus.exRegWrite_in),
      .ex_mem_read_i  (bus.exMemRead_in),
      .ex_result_i    (bus.exResult_in),
      .wb_rd_i        (bus.wbRd_in),
      .wb_reg_write_i (bus.wbRegWrite_in),
      .wb_data_i      (bus.wbData_in),
      .data_o         (fwd2),
      .stall_o        (haz2)
   );

   always_comb begin
      hazard  = haz1 || haz2;
      valid   = (state_q == StFull);
      ready   = !hazard && (!valid || bus.ready_in) && !bus.flush_in;
      accept  = bus.inst_valid_in && ready;
      state_d = state_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      ctrl_d  = ctrl_q;
      if (accept) begin
         op1_d  = fwd1;
         op2_d  = fwd2;
         ctrl_d = '{rd: bus.rd_in, reg_write: bus.regWrite_in, mem_read: bus.memRead_in};
      end
      unique case (state_q)
         StEmpty: if (accept) state_d = StFull;
         StFull: begin
            // Flush beats accept and stall; a hazard with ready_in leaves a bubble.
            if (bus.flush_in)                  state_d = StEmpty;
            else if (!accept && bus.ready_in)  state_d = StEmpty;
         end
         default: state_d = StEmpty;
      endcase
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q <= StEmpty;
         op1_q   <= '0;
         op2_q   <= '0;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign bus.inst_ready_out = ready;
   assign bus.valid_out      = valid;
   assign bus.op1_out        = op1_q;
   assign bus.op2_out        = op2_q;
   assign bus.rd_out         = ctrl_q.rd;
   assign bus.regWrite_out   = ctrl_q.reg_write;
   assign bus.memRead_out    = ctrl_q.mem_read;

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: directed scenarios plus randomized traffic
// compared every cycle against a "newest architectural value" model.
module tb_operand_stage;
   import operand_stage_pkg::*;

   localparam int unsigned Pow = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   bit   chk_en = 1'b0;

   logic [63:0] rf [32];

   logic        m_valid = 1'b0;
   logic [63:0] m_op1 = '0, m_op2 = '0;
   logic [4:0]  m_rd = '0;
   logic        m_rw = 1'b0, m_mr = 1'b0;

   operand_stage_if #(.DATA_WIDTH_POW(Pow)) bus ();

   operand_stage #(.DATA_WIDTH_POW(Pow)) dut (
      .clk_in (clk),
      .reset  (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   assign bus.rs1Data_in = rf[bus.rs1_in];
   assign bus.rs2Data_in = rf[bus.rs2_in];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Would consuming this source now read a value not yet obtainable?
   function automatic logic src_blocked(input logic [4:0] rs);
      if (rs == 5'd0) return 1'b0;
`ifdef OPERAND_FORWARD_EN
      return bus.exRegWrite_in && bus.exMemRead_in && bus.exRd_in == rs;
`else
      return (bus.exRegWrite_in && bus.exRd_in == rs) || (bus.wbRegWrite_in && bus.wbRd_in == rs);
`endif
   endfunction

   // Value program order says the register holds for this instruction.
   function automatic logic [63:0] newest(input logic [4:0] rs);
      if (rs == 5'd0) return 64'd0;
      if (bus.exRegWrite_in && bus.exRd_in == rs && !bus.exMemRead_in) return bus.exResult_in;
      if (bus.wbRegWrite_in && bus.wbRd_in == rs) return bus.wbData_in;
      return rf[rs];
   endfunction

   function automatic logic model_ready();
      return !(src_blocked(bus.rs1_in) || src_blocked(bus.rs2_in)) &&
             (!m_valid || bus.ready_in) && !bus.flush_in;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid = 1'b0; m_op1 = '0; m_op2 = '0; m_rd = '0; m_rw = 1'b0; m_mr = 1'b0;
      end else begin
         if (bus.flush_in) begin
            m_valid = 1'b0;
         end else if (bus.inst_valid_in && model_ready()) begin
            m_valid = 1'b1;
            m_op1   = newest(bus.rs1_in);
            m_op2   = newest(bus.rs2_in);
            m_rd    = bus.rd_in;
            m_rw    = bus.regWrite_in;
            m_mr    = bus.memRead_in;
         end else if (m_valid && bus.ready_in) begin
            m_valid = 1'b0;
         end
         if (bus.wbRegWrite_in && bus.wbRd_in != 5'd0) rf[bus.wbRd_in] <= bus.wbData_in;
      end
   end

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         check("m_ready", {63'd0, bus.inst_ready_out}, {63'd0, model_ready()});
         check("m_valid", {63'd0, bus.valid_out}, {63'd0, m_valid});
         if (m_valid) begin
            check("m_op1", bus.op1_out, m_op1);
            check("m_op2", bus.op2_out, m_op2);
            check("m_rd", {59'd0, bus.rd_out}, {59'd0, m_rd});
            check("m_ctrl", {62'd0, bus.regWrite_out, bus.memRead_out}, {62'd0, m_rw, m_mr});
         end
      end
   end

   task automatic set_idle();
      bus.inst_valid_in = 1'b0; bus.rs1_in = '0; bus.rs2_in = '0; bus.rd_in = '0;
      bus.regWrite_in = 1'b0; bus.memRead_in = 1'b0;
      bus.exRd_in = '0; bus.exRegWrite_in = 1'b0; bus.exMemRead_in = 1'b0; bus.exResult_in = '0;
      bus.wbRd_in = '0; bus.wbRegWrite_in = 1'b0; bus.wbData_in = '0;
      bus.flush_in = 1'b0; bus.ready_in = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
      bus.inst_valid_in = 1'b1; bus.rs1_in = r1; bus.rs2_in = r2; bus.rd_in = rd;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 64'h100 + 64'(i);
      rf[0] = '0; rf[5] = 64'h11; rf[7] = 64'h70;
      set_idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      check("reset_valid", {63'd0, bus.valid_out}, 64'd0);
      check("reset_op1", bus.op1_out, 64'd0);

      // Plain register-file read.
      issue(5'd5, 5'd0, 5'd3); bus.regWrite_in = 1'b1;
      #2 check("rf_ready", {63'd0, bus.inst_ready_out}, 64'd1);
      step();
      check("rf_valid", {63'd0, bus.valid_out}, 64'd1);
      check("rf_op1", bus.op1_out, 64'h11);
      check("rf_rd", {59'd0, bus.rd_out}, 64'd3);

      // EX and WB both write x5.
      set_idle(); issue(5'd5, 5'd0, 5'd4);
      bus.exRd_in = 5'd5; bus.exRegWrite_in = 1'b1; bus.exResult_in = 64'h22;
      bus.wbRd_in = 5'd5; bus.wbRegWrite_in = 1'b1; bus.wbData_in = 64'h33;
`ifdef OPERAND_FORWARD_EN
      #2 check("exprio_ready", {63'd0, bus.inst_ready_out}, 64'd1);
      step();
      check("exprio_op1", bus.op1_out, 64'h22);
`else
      #2 check("raw_stall", {63'd0, bus.inst_ready_out}, 64'd0);
      step();
      check("raw_bubble", {63'd0, bus.valid_out}, 64'd0);
      set_idle(); issue(5'd5, 5'd0, 5'd4);
      #2 check("raw_release", {63'd0, bus.inst_ready_out}, 64'd1);
      step();
      check("raw_op1", bus.op1_out, 64'h33);
`endif

      // Load-use on x7.
      set_idle(); issue(5'd1, 5'd2, 5'd9);
      step();
      set_idle(); issue(5'd0, 5'd7, 5'd8);
      bus.exRd_in = 5'd7; bus.exRegWrite_in = 1'b1; bus.exMemRead_in = 1'b1;
      bus.exResult_in = 64'hDEAD;
      #2 check("lu_ready", {63'd0, bus.inst_ready_out}, 64'd0);
      step();
      check("lu_bubble", {63'd0, bus.valid_out}, 64'd0);
      bus.exRegWrite_in = 1'b0; bus.exMemRead_in = 1'b0; bus.exRd_in = '0;
      bus.wbRd_in = 5'd7; bus.wbRegWrite_in = 1'b1; bus.wbData_in = 64'hAB;
`ifndef OPERAND_FORWARD_EN
      #2 check("lu_wb_stall", {63'd0, bus.inst_ready_out}, 64'd0);
      step();
      bus.wbRegWrite_in = 1'b0; bus.wbRd_in = '0;
`endif
      step();
      check("lu_valid", {63'd0, bus.valid_out}, 64'd1);
      check("lu_op2", bus.op2_out, 64'hAB);

      // x0 never forwards.
      set_idle(); issue(5'd0, 5'd0, 5'd2);
      bus.exRd_in = 5'd0; bus.exRegWrite_in = 1'b1; bus.exResult_in = 64'hFF;
      step();
      check("x0_op1", bus.op1_out, 64'd0);
      check("x0_valid", {63'd0, bus.valid_out}, 64'd1);

      // Downstream stall, then flush.
      set_idle(); issue(5'd3, 5'd4, 5'd9); bus.regWrite_in = 1'b1;
      step();
      check("st_op1", bus.op1_out, 64'h103);
      check("st_op2", bus.op2_out, 64'h104);
      bus.ready_in = 1'b0; issue(5'd1, 5'd2, 5'd10);
      for (int c = 0; c < 3; c++) begin
         #2 check("st_ready", {63'd0, bus.inst_ready_out}, 64'd0);
         step();
         check("st_valid", {63'd0, bus.valid_out}, 64'd1);
         check("st_hold_op1", bus.op1_out, 64'h103);
         check("st_hold_rd", {59'd0, bus.rd_out}, 64'd9);
      end
      bus.flush_in = 1'b1;
      step();
      check("flush_valid", {63'd0, bus.valid_out}, 64'd0);

      // Asynchronous reset while FULL.
      set_idle(); issue(5'd3, 5'd0, 5'd6); bus.regWrite_in = 1'b1; bus.memRead_in = 1'b1;
      step();
      check("pre_rst_valid", {63'd0, bus.valid_out}, 64'd1);
      bus.inst_valid_in = 1'b0; bus.ready_in = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("arst_valid", {63'd0, bus.valid_out}, 64'd0);
      check("arst_op1", bus.op1_out, 64'd0);
      check("arst_rd", {59'd0, bus.rd_out}, 64'd0);
      check("arst_ctrl", {62'd0, bus.regWrite_out, bus.memRead_out}, 64'd0);
      step();
      rst = 1'b0;
      set_idle(); issue(5'd2, 5'd0, 5'd1);
      #1 check("post_rst_ready", {63'd0, bus.inst_ready_out}, 64'd1);
      step();
      check("post_rst_op1", bus.op1_out, 64'h102);

      // Randomized traffic, checked by the model each negedge.
      for (int n = 0; n < 800; n++) begin
         bus.inst_valid_in = ($urandom_range(0, 9) < 7);
         bus.rs1_in        = 5'($urandom_range(0, 7));
         bus.rs2_in        = 5'($urandom_range(0, 7));
         bus.rd_in         = 5'($urandom_range(0, 7));
         bus.regWrite_in   = 1'($urandom);
         bus.memRead_in    = 1'($urandom);
         bus.exRd_in       = 5'($urandom_range(0, 7));
         bus.exRegWrite_in = ($urandom_range(0, 9) < 6);
         bus.exMemRead_in  = ($urandom_range(0, 9) < 3);
         bus.exResult_in   = {$urandom, $urandom};
         bus.wbRd_in       = 5'($urandom_range(0, 7));
         bus.wbRegWrite_in = ($urandom_range(0, 9) < 6);
         bus.wbData_in     = {$urandom, $urandom};
         bus.flush_in      = ($urandom_range(0, 19) == 0);
         bus.ready_in      = ($urandom_range(0, 3) != 0);
         step();
      end

      set_idle();
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 Parameter: DATA_WIDTH_POW, default 6, operand width DATA_WIDTH = 1 << DATA_WIDTH_POW.
REQ-002 clk_in  input  1  sole clock, all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 inst_valid_in  input  1  upstream decoded instruction valid.
REQ-005 inst_ready_out  output  1  stage can accept this cycle.
REQ-006 rs1_in, rs2_in, rd_in  input  5 each  source and destination register numbers.
REQ-007 regWrite_in, memRead_in  input  1 each  instruction writes rd / instruction is a load.
REQ-008 rs1Data_in, rs2Data_in  input  DATA_WIDTH each  combinational register-file read data.
REQ-009 exRd_in, exRegWrite_in, exMemRead_in, exResult_in  input  5/1/1/DATA_WIDTH  execute-stage destination info and result.
REQ-010 wbRd_in, wbRegWrite_in, wbData_in  input  5/1/DATA_WIDTH  writeback port, same values driven to the register file.
REQ-011 flush_in  input  1  discard held and incoming instruction.
REQ-012 ready_in  input  1  downstream execute stage accepts.
REQ-013 valid_out, op1_out, op2_out, rd_out, regWrite_out, memRead_out  output  1/DATA_WIDTH/DATA_WIDTH/5/1/1  registered operand bundle.

Function
REQ-014 Accept occurs when inst_valid_in && inst_ready_out, and the bundle appears on the outputs one cycle later (latency 1).
REQ-015 Forwarding priority per source: rs==0 gives 0; else EX match (exRegWrite_in, exRd_in==rs, not load) gives exResult_in; else WB match gives wbData_in; else register-file data.
REQ-016 WB forwarding covers the register file's same-edge write, since a read in the write cycle returns the old value.
REQ-017 Load-use hazard: exRegWrite_in && exMemRead_in && exRd_in!=0 && exRd_in matches a used rs → inst_ready_out=0 for that cycle.
REQ-018 A load-use hazard with valid_out && ready_in inserts a bubble, valid_out=0 next cycle.
REQ-019 Downstream stall (valid_out && !ready_in) holds all outputs stable and drives inst_ready_out=0.
REQ-020 inst_ready_out = !hazard && (!valid_out || ready_in) && !flush_in.
REQ-021 flush_in clears valid_out next cycle; flush wins over simultaneous accept or stall.
REQ-022 Two-state control (EMPTY, FULL) tracked by valid_out: EMPTY→FULL on accept; FULL→EMPTY on ready_in without accept, or on flush; FULL→FULL on stall or on accept with ready_in.
REQ-023 When valid_out=0, the output data fields are don't-care but deterministic (last value held).

Reset
REQ-024 reset asynchronously clears valid_out, op1_out, op2_out, rd_out, regWrite_out and memRead_out to 0.
REQ-025 Reset mid-operation drops the held instruction, and inst_ready_out is 1 on the first cycle after release.

Configuration
REQ-026 Macro OPERAND_FORWARD_EN defined: forwarding per REQ-015/016 is active.
REQ-027 Macro undefined: no bypass, and any EX or WB RAW match on a used rs stalls, like REQ-017, until the register file holds the value.

Structure
REQ-028 The shared package holds DATA_WIDTH derivation, REG_ADDR_W=5 and the operand-bundle struct typedef.
REQ-029 One sub-module, operand_fwd_mux: combinational per-source selection, instantiated twice.

Verification
REQ-030 Verify: rs1=5, regfile x5=0x11, no matches → op1_out=0x11, valid_out=1 one cycle after accept.
REQ-031 Verify: exRd=5 ALU result 0x22, WB rd=5 data 0x33 → op1_out=0x22 (EX priority); without OPERAND_FORWARD_EN → stall.
REQ-032 Verify: load into x7 in EX, rs2=7 → inst_ready_out=0 one cycle, bubble, then op2_out = WB-forwarded load data.
REQ-033 Verify: rs1=0 with exRd=0, exRegWrite=1, result 0xFF → op1_out=0.
REQ-034 Verify: ready_in=0 for 3 cycles → outputs constant, inst_ready_out=0; flush_in during stall → valid_out=0 next cycle.
REQ-035 Verify: reset asserted mid-FULL asynchronously → all outputs 0 immediately.
